leb128_gather_u32: RTL and testbench
====================================

# leb128_gather_u32

Byte-stream front end for the u32 LEB128 decoder. It accepts one encoded byte per cycle over a valid/ready handshake and groups the bytes of one LEB128 value, up to 5. It then presents them as a 5-byte window i0..i4 with a valid/ready handshake directly to the combinational unpack stage. Captured bytes have bit 7 cleared, and unused slots are padded with 8'h80, so the unpack stage zeroes them. It also flags encodings that overflow 32 bits.

## Interface
- No parameters; width fixed to u32 (5 slots × 7 bits).
- clk  input  1  clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- s_data  input  8  encoded byte; bit 7 = continuation, bits 6:0 = chunk
- s_valid  input  1  s_data valid
- s_ready  output  1  byte accepted when s_valid && s_ready
- o0..o4  output  8 each  window to unpack stage, o0 = least significant chunk
- len  output  3  number of bytes captured in this window, 1..5
- err  output  1  value overflowed u32 (see Operation)
- t_valid  output  1  window valid
- t_ready  input  1  window consumed when t_valid && t_ready

## Operation
- States: COLLECT (cnt 0..4), SKIP, FULL. Reset state is COLLECT, cnt=0.
- Reset values:
  - o0..o4 = 8'h80.
  - len = 0, err = 0, t_valid = 0.
  - s_ready = 1, as a combinational decode of the reset state.
- s_ready: 1 in COLLECT and SKIP; equals t_ready in FULL.
- t_valid is 1 only in FULL.
- COLLECT, byte b accepted:
  - Write slot[cnt] = {1'b0, b[6:0]}.
  - If b[7]==0: go to FULL, len=cnt+1, err = (cnt==4) && (b[6:4]!=0).
  - Else if cnt==4: go to SKIP, len=5, err=1.
  - Else cnt = cnt+1.
- SKIP: accepted bytes are discarded and slots are untouched. An accepted byte with b[7]==0 moves the block to FULL with err=1 held.
- FULL: o0..o4, len and err are held stable while t_valid && !t_ready.
- Handshake out (t_valid && t_ready):
  - Return to COLLECT with cnt=0.
  - All slots = 8'h80, len and err cleared.
  - Exception, simultaneous byte accept: because s_ready = t_ready in FULL, a byte accepted in the same cycle is processed as byte 0 of the new group:
    - slot0 = {0, b[6:0]}, with slots 1..4 = 80.
    - The COLLECT rules above apply to that byte, including going straight to FULL when b[7]==0.
- Width rule: slot k carries result bits [7k+6:7k]. Slot 4 contributes only bits 3:0; nonzero bits 6:4 in slot 4 set err, but the window is still emitted unmodified.
- Reset mid-group (reset_n low at any time):
  - All state returns to reset values immediately.
  - Partially gathered bytes are lost.
  - The first byte accepted after release starts a new group.
- s_data is ignored when s_valid=0. t_ready is ignored outside FULL.

## Timing
- Latency: t_valid rises the cycle after the edge on which the terminating byte is accepted.
- Throughput: 1 byte per cycle sustained, including with FULL→COLLECT overlap. Single-byte values stream as one window per cycle when t_ready is held high.
- All outputs are registered except s_ready, which is combinational from state and t_ready.
- No combinational path from s_valid/s_data to any output.

## Test plan
- **Single-byte value.** Reset, then s_data 8'h05 accepted.
  - Next cycle: t_valid=1, o={05,80,80,80,80}, len=1, err=0.
  - Unpack stage yields 32'h5.
- **Three-byte value, held output.** Bytes E5 8E 26.
  - Window o0=65, o1=0E, o2=26, o3=80, o4=80, len=3, err=0, giving 32'h00098765.
  - Hold t_ready=0 for 4 cycles: outputs stable and s_ready=0.
- **Five-byte maximum.** Bytes FF FF FF FF 0F give len=5, err=0, window {7F,7F,7F,7F,0F}, value 32'hFFFFFFFF.
  - Repeat with last byte 1F: err=1, o4=1F.
- **Overlong encoding.** Bytes FF FF FF FF FF 7F, then 01.
  - After FF×5: state SKIP, s_ready=1, t_valid=0.
  - 7F accepted: t_valid=1, err=1, len=5.
  - On handshake, the group containing 01 follows with err=0, len=1.
- **Back-to-back overlap.** t_ready=1, s_valid=1 streaming 01, 02, 03 on consecutive cycles.
  - t_valid stays high for 3 consecutive cycles with o0 = 01, 02, 03, len=1.
  - No bubbles.
- **Reset mid-operation.** Accept E5 8E, then pulse reset_n low for one cycle mid-cycle.
  - All outputs return to reset values asynchronously.
  - After release, byte 26 gives window {26,80,80,80,80}, len=1.

Source files
------------

// File: rtl/leb128_gather_u32_if.sv
// ---------------------------------------------------------------------------
// leb128_gather_u32_if
// Byte-stream input handshake and 5-byte window output handshake of the
// u32 LEB128 gather stage.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface leb128_gather_u32_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] o0;
  logic [7:0] o1;
  logic [7:0] o2;
  logic [7:0] o3;
  logic [7:0] o4;
  logic [2:0] len;
  logic       err;
  logic       t_valid;
  logic       t_ready;

  // Gather block side
  modport slave (
    input  s_data, s_valid, t_ready,
    output s_ready, o0, o1, o2, o3, o4, len, err, t_valid
  );

  // Byte producer / unpack consumer side
  modport master (
    output s_data, s_valid, t_ready,
    input  s_ready, o0, o1, o2, o3, o4, len, err, t_valid
  );
endinterface

`default_nettype wire

// File: rtl/leb128_gather_u32.sv
// ---------------------------------------------------------------------------
// leb128_gather_u32
// Collects the bytes of one u32 LEB128 value (max 5) into a window of
// 7-bit chunks with bit 7 cleared; unused slots hold 8'h80. Flags values
// that overflow 32 bits. Overlong encodings are drained until their
// terminating byte.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module leb128_gather_u32 (
  input  wire logic            clk,
  input  wire logic            reset_n,
  leb128_gather_u32_if.slave   bus
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SKIP    = 2'd1,
    FULL    = 2'd2
  } state_t;

  localparam logic [7:0] PAD = 8'h80;

  state_t     state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic [7:0] slot    [5];
  logic [7:0] slot_nx [5];
  logic [2:0] len_q, len_nx;
  logic       err_q, err_nx;
  logic       t_valid_q;

  logic       s_ready;
  logic       accept;
  logic       take;
  logic [2:0] idx;

  // Input ready: always open except while a window waits for its consumer
  always_comb begin
    s_ready = (state != FULL) || bus.t_ready;
    accept  = bus.s_valid && s_ready;
  end

  // Next-state and window datapath
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    slot_nx  = slot;
    len_nx   = len_q;
    err_nx   = err_q;
    take     = 1'b0;
    idx      = cnt;

    case (state)
      COLLECT: begin
        take = accept;
        idx  = cnt;
      end
      SKIP: begin
        // Overlong tail: discard bytes, keep window and err until terminator
        if (accept && !bus.s_data[7]) begin
          state_nx = FULL;
        end
      end
      FULL: begin
        if (bus.t_ready) begin
          state_nx = COLLECT;
          cnt_nx   = 3'd0;
          for (int k = 0; k < 5; k++) begin
            slot_nx[k] = PAD;
          end
          len_nx = 3'd0;
          err_nx = 1'b0;
          // A byte arriving with the handshake opens the next group
          take   = bus.s_valid;
          idx    = 3'd0;
        end
      end
      default: begin
        state_nx = COLLECT;
        cnt_nx   = 3'd0;
      end
    endcase

    if (take) begin
      for (int k = 0; k < 5; k++) begin
        if (idx == 3'(k)) begin
          slot_nx[k] = {1'b0, bus.s_data[6:0]};
        end
      end
      if (!bus.s_data[7]) begin
        state_nx = FULL;
        len_nx   = idx + 3'd1;
        // Slot 4 only carries result bits 31:28
        err_nx   = (idx == 3'd4) && (bus.s_data[6:4] != 3'd0);
      end else if (idx == 3'd4) begin
        state_nx = SKIP;
        len_nx   = 3'd5;
        err_nx   = 1'b1;
      end else begin
        state_nx = COLLECT;
        cnt_nx   = idx + 3'd1;
      end
    end
  end

  // State and window registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= COLLECT;
      cnt       <= 3'd0;
      for (int k = 0; k < 5; k++) begin
        slot[k] <= PAD;
      end
      len_q     <= 3'd0;
      err_q     <= 1'b0;
      t_valid_q <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      for (int k = 0; k < 5; k++) begin
        slot[k] <= slot_nx[k];
      end
      len_q     <= len_nx;
      err_q     <= err_nx;
      t_valid_q <= (state_nx == FULL);
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.o0      = slot[0];
  assign bus.o1      = slot[1];
  assign bus.o2      = slot[2];
  assign bus.o3      = slot[3];
  assign bus.o4      = slot[4];
  assign bus.len     = len_q;
  assign bus.err     = err_q;
  assign bus.t_valid = t_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_leb128_gather_u32.sv
// ---------------------------------------------------------------------------
// tb_leb128_gather_u32
// Directed table of encodings plus hand-written multi-cycle sequences for
// held output, overlong drain, back-to-back overlap and async reset.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_leb128_gather_u32;

  logic clk;
  logic reset_n;

  leb128_gather_u32_if bus();

  leb128_gather_u32 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  typedef struct {
    int          nb;
    logic [47:0] b;    // byte k at [8k+7:8k]
    logic [39:0] o;    // {o4,o3,o2,o1,o0}
    logic [2:0]  len;
    logic        err;
    logic [31:0] val;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] window();
    return {bus.o4, bus.o3, bus.o2, bus.o1, bus.o0};
  endfunction

  // Reference unpack: padded slots (bit 7 set) contribute nothing
  function automatic logic [31:0] unpack(input logic [39:0] w);
    logic [63:0] acc;
    acc = 64'd0;
    for (int k = 0; k < 5; k++) begin
      if (!w[8*k+7]) acc = acc | (64'(w[8*k +: 7]) << (7*k));
    end
    return acc[31:0];
  endfunction

  // Offer one byte at the falling edge, wait (bounded) for acceptance
  task automatic send(input logic [7:0] b);
    int wait_cnt;
    @(negedge clk);
    bus.s_data  = b;
    bus.s_valid = 1'b1;
    wait_cnt = 0;
    while (!bus.s_ready && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (!bus.s_ready) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: s_ready stuck at 0 for byte %0h", b);
    end
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_o"},       64'(window()),      64'h8080808080);
    chk({tag, "_len"},     64'(bus.len),       64'd0);
    chk({tag, "_err"},     64'(bus.err),       64'd0);
    chk({tag, "_t_valid"}, 64'(bus.t_valid),   64'd0);
    chk({tag, "_s_ready"}, 64'(bus.s_ready),   64'd1);
  endtask

  // One handshake cycle with no new byte, then expect the idle state
  task automatic drain(input string tag);
    @(negedge clk);
    bus.t_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.t_ready = 1'b0;
    check_reset_vals(tag);
  endtask

  initial begin
    logic [39:0] w0;
    checks = 0;
    errors = 0;
    bus.s_data  = 8'h00;
    bus.s_valid = 1'b0;
    bus.t_ready = 1'b0;
    reset_n     = 1'b0;

    vecs[0] = '{nb:1, b:48'h000000000005, o:40'h8080808005, len:3'd1, err:1'b0, val:32'h00000005};
    vecs[1] = '{nb:3, b:48'h000000268EE5, o:40'h8080260E65, len:3'd3, err:1'b0, val:32'h00098765};
    vecs[2] = '{nb:5, b:48'h000FFFFFFFFF, o:40'h0F7F7F7F7F, len:3'd5, err:1'b0, val:32'hFFFFFFFF};
    vecs[3] = '{nb:5, b:48'h001FFFFFFFFF, o:40'h1F7F7F7F7F, len:3'd5, err:1'b1, val:32'hFFFFFFFF};
    vecs[4] = '{nb:2, b:48'h000000000080, o:40'h8080800000, len:3'd2, err:1'b0, val:32'h00000000};
    vecs[5] = '{nb:1, b:48'h00000000007F, o:40'h808080807F, len:3'd1, err:1'b0, val:32'h0000007F};
    vecs[6] = '{nb:6, b:48'h7FFFFFFFFFFF, o:40'h7F7F7F7F7F, len:3'd5, err:1'b1, val:32'hFFFFFFFF};
    vecs[7] = '{nb:5, b:48'h000080808080, o:40'h0000000000, len:3'd5, err:1'b0, val:32'h00000000};
    vecs[8] = '{nb:2, b:48'h000000000181, o:40'h8080800101, len:3'd2, err:1'b0, val:32'h00000081};
    vecs[9] = '{nb:4, b:48'h00007FFFFFFF, o:40'h807F7F7F7F, len:3'd4, err:1'b0, val:32'h0FFFFFFF};

    // Reset state
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Table-driven windows
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < vecs[i].nb; j++) send(vecs[i].b[8*j +: 8]);
      chk($sformatf("v%0d_t_valid", i), 64'(bus.t_valid), 64'd1);
      chk($sformatf("v%0d_o", i),       64'(window()),    64'(vecs[i].o));
      chk($sformatf("v%0d_len", i),     64'(bus.len),     64'(vecs[i].len));
      chk($sformatf("v%0d_err", i),     64'(bus.err),     64'(vecs[i].err));
      chk($sformatf("v%0d_val", i),     64'(unpack(window())), 64'(vecs[i].val));
      drain($sformatf("v%0d_after", i));
    end

    // Held output: window and len stable, s_ready low while t_ready low
    send(8'hE5); send(8'h8E); send(8'h26);
    w0 = window();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_data  = 8'h33;
      chk($sformatf("hold%0d_o", c),       64'(window()),    64'h8080260E65);
      chk($sformatf("hold%0d_len", c),     64'(bus.len),     64'd3);
      chk($sformatf("hold%0d_t_valid", c), 64'(bus.t_valid), 64'd1);
      chk($sformatf("hold%0d_s_ready", c), 64'(bus.s_ready), 64'd0);
    end
    bus.s_valid = 1'b0;
    chk("hold_w0", 64'(w0), 64'h8080260E65);
    drain("hold_after");

    // Overlong: SKIP after five continuation bytes, then terminator, then overlap
    for (int j = 0; j < 5; j++) send(8'hFF);
    @(negedge clk);
    chk("skip_s_ready", 64'(bus.s_ready), 64'd1);
    chk("skip_t_valid", 64'(bus.t_valid), 64'd0);
    send(8'hFF);
    chk("skip2_t_valid", 64'(bus.t_valid), 64'd0);
    send(8'h7F);
    chk("ovl_t_valid", 64'(bus.t_valid), 64'd1);
    chk("ovl_err",     64'(bus.err),     64'd1);
    chk("ovl_len",     64'(bus.len),     64'd5);
    chk("ovl_o",       64'(window()),    64'h7F7F7F7F7F);
    @(negedge clk);
    bus.t_ready = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h01;
    @(posedge clk);
    #1;
    bus.t_ready = 1'b0;
    bus.s_valid = 1'b0;
    chk("ovl_next_t_valid", 64'(bus.t_valid), 64'd1);
    chk("ovl_next_err",     64'(bus.err),     64'd0);
    chk("ovl_next_len",     64'(bus.len),     64'd1);
    chk("ovl_next_o",       64'(window()),    64'h8080808001);
    drain("ovl_after");

    // Back-to-back single-byte windows with t_ready held high
    @(negedge clk);
    bus.t_ready = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'(c);
      @(posedge clk);
      #1;
      chk($sformatf("b2b%0d_t_valid", c), 64'(bus.t_valid), 64'd1);
      chk($sformatf("b2b%0d_o", c),       64'(window()),    64'h8080808000 | 64'(c));
      chk($sformatf("b2b%0d_len", c),     64'(bus.len),     64'd1);
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    @(posedge clk);
    #1;
    bus.t_ready = 1'b0;
    check_reset_vals("b2b_after");

    // Asynchronous reset while a window is presented
    send(8'h05);
    chk("rstfull_t_valid_pre", 64'(bus.t_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("rstfull");
    @(negedge clk);
    reset_n = 1'b1;

    // Reset mid-group: partial bytes are lost
    send(8'hE5); send(8'h8E);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("rstmid");
    @(negedge clk);
    reset_n = 1'b1;
    send(8'h26);
    chk("rstmid_t_valid", 64'(bus.t_valid), 64'd1);
    chk("rstmid_o",       64'(window()),    64'h8080808026);
    chk("rstmid_len",     64'(bus.len),     64'd1);
    chk("rstmid_err",     64'(bus.err),     64'd0);
    drain("rstmid_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
